// File: rtl/ws2812_chain_driver.sv
// ws2812_chain_driver: streams pixel words from a synchronous RAM as WS2812 pulse-width bits, then latches.
// Optional WS2812_BRIGHTNESS_EN adds a brightness port that scales every 8-bit channel.
module ws2812_chain_driver #(
    parameter int BITS_PER_LED = 24,
    parameter int ADDR_W       = 6,
    parameter int TIMER_W      = 16,
    parameter int T0H          = 18,
    parameter int T0L          = 40,
    parameter int T1H          = 35,
    parameter int T1L          = 30,
    parameter int RES          = 2500
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [ADDR_W:0]         num_leds,
    input  logic [BITS_PER_LED-1:0] data,
    output logic [ADDR_W-1:0]       address,
    output logic                    out,
    output logic                    busy,
    output logic                    done
`ifdef WS2812_BRIGHTNESS_EN
    ,
    input  logic [7:0]              brightness
`endif
);
    localparam int BIT_W = $clog2(BITS_PER_LED);
    localparam logic [TIMER_W-1:0] H0 = TIMER_W'(T0H - 1);
    localparam logic [TIMER_W-1:0] H1 = TIMER_W'(T1H - 1);
    localparam logic [TIMER_W-1:0] L0 = TIMER_W'(T0L - 1);
    localparam logic [TIMER_W-1:0] L1 = TIMER_W'(T1L - 1);
    localparam logic [ADDR_W:0] NMAX = {1'b1, {ADDR_W{1'b0}}};

    typedef enum logic [2:0] {IDLE, FETCH, LOAD, HIGH, LOW, LATCH} state_t;
    state_t state, state_n;

    logic [TIMER_W-1:0]      timer;
    logic [BITS_PER_LED-1:0] shreg, hold, data_s;
    logic [BIT_W-1:0]        bit_idx;
    logic [ADDR_W-1:0]       led_idx;
    logic [ADDR_W:0]         n_lat, n_sat, led_nxt;
    logic [1:0]              pf;
    logic                    tz, last_bit, last_led, nxt_last, adv;

`ifdef WS2812_BRIGHTNESS_EN
    logic [7:0] bri;
    for (genvar c = 0; c < BITS_PER_LED / 8; c++) begin : g_ch
        assign data_s[8*c +: 8] = 8'((16'(data[8*c +: 8]) * (16'(bri) + 16'd1)) >> 8);
    end
`else
    assign data_s = data;
`endif

    assign tz       = timer == '0;
    assign last_bit = bit_idx == BIT_W'(BITS_PER_LED - 1);
    assign led_nxt  = {1'b0, led_idx} + 1'b1;
    assign last_led = led_nxt == n_lat;
    assign nxt_last = led_nxt + 1'b1 == n_lat;
    assign n_sat    = num_leds > NMAX ? NMAX : num_leds;
    // Address advances on every load of a non-final LED; the inter-LED load happens straight from LOW
    assign adv = (state == LOAD && !last_led) ||
                 (state == LOW && tz && last_bit && !last_led && !nxt_last);

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE:    state_n = start ? (num_leds == '0 ? LATCH : FETCH) : IDLE;
            FETCH:   state_n = LOAD;
            LOAD:    state_n = HIGH;
            HIGH:    state_n = tz ? LOW : HIGH;
            LOW:     state_n = !tz ? LOW : (last_bit && last_led) ? LATCH : HIGH;
            LATCH:   state_n = tz ? IDLE : LATCH;
            default: state_n = IDLE;
        endcase
    end

    always_comb begin
        out  = state == HIGH;
        busy = state != IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            timer   <= '0;
            shreg   <= '0;
            hold    <= '0;
            bit_idx <= '0;
            led_idx <= '0;
            n_lat   <= '0;
            pf      <= '0;
            address <= '0;
            done    <= 1'b0;
`ifdef WS2812_BRIGHTNESS_EN
            bri     <= '0;
`endif
        end else begin
            done <= 1'b0;
            pf   <= {pf[0], adv};
            if (pf[1]) hold <= data_s;
            if (adv) address <= address + 1'b1;
            unique case (state)
                IDLE: if (start) begin
                    n_lat   <= n_sat;
                    led_idx <= '0;
                    address <= '0;
                    // the empty frame spends one extra cycle so done lands at E0+1+RES
                    timer   <= num_leds == '0 ? TIMER_W'(RES) : '0;
`ifdef WS2812_BRIGHTNESS_EN
                    bri     <= brightness;
`endif
                end
                LOAD: begin
                    shreg   <= data_s;
                    bit_idx <= '0;
                    timer   <= data_s[BITS_PER_LED-1] ? H1 : H0;
                end
                HIGH: timer <= tz ? (shreg[BITS_PER_LED-1] ? L1 : L0) : timer - 1'b1;
                LOW: begin
                    if (!tz) timer <= timer - 1'b1;
                    else if (!last_bit) begin
                        shreg   <= shreg << 1;
                        bit_idx <= bit_idx + 1'b1;
                        timer   <= shreg[BITS_PER_LED-2] ? H1 : H0;
                    end else if (last_led) timer <= TIMER_W'(RES - 1);
                    else begin
                        shreg   <= hold;
                        bit_idx <= '0;
                        led_idx <= led_idx + 1'b1;
                        timer   <= hold[BITS_PER_LED-1] ? H1 : H0;
                    end
                end
                LATCH: begin
                    if (tz) begin
                        done    <= 1'b1;
                        address <= '0;
                    end else timer <= timer - 1'b1;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_ws2812_chain_driver.sv
// tb_ws2812_chain_driver: scoreboard bench decoding the LED line into bits, done timing and address steps.
module tb_ws2812_chain_driver;
    localparam int T0H = 3, T0L = 5, T1H = 5, T1L = 3, RES = 10, BITS = 24, AW = 6;

    logic            clk = 1'b0, rst = 1'b1, start = 1'b0;
    logic [AW:0]     num_leds = '0;
    logic [BITS-1:0] data = '0;
    logic [AW-1:0]   address;
    logic            out, busy, done;
`ifdef WS2812_BRIGHTNESS_EN
    logic [7:0]      brightness = 8'd255;
`endif

    ws2812_chain_driver #(
        .BITS_PER_LED(BITS), .ADDR_W(AW), .TIMER_W(16),
        .T0H(T0H), .T0L(T0L), .T1H(T1H), .T1L(T1L), .RES(RES)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .num_leds(num_leds), .data(data),
        .address(address), .out(out), .busy(busy), .done(done)
`ifdef WS2812_BRIGHTNESS_EN
        , .brightness(brightness)
`endif
    );

    always #5 clk = ~clk;

    logic [BITS-1:0] mem [64];
    logic [BITS-1:0] expw[64];
    always @(posedge clk) data <= mem[address];

    int cyc = 0;
    always @(posedge clk) cyc++;

    int checks = 0, errors = 0;
    bit exp_bits[$];
    int exp_done[$];
    int exp_addr[$];
    int hc = 0, lc = 0, prev_addr = 0, last_e0 = 0;
    bit in_bit = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_bit(input int extra);
        bit b;
        if (exp_bits.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_bit: got high pulse of %0d expected none", hc);
            return;
        end
        b = exp_bits.pop_front();
        chk("bit_high", hc, b ? T1H : T0H);
        chk("bit_low", lc, (b ? T1L : T0L) + extra);
    endtask

    // Monitor: measures each high/low run on the line and pops the expected bit when the next one starts
    always @(negedge clk) begin
        if (!rst) begin
            if (done) begin
                if (in_bit) check_bit(RES);
                in_bit = 0;
                chk("done_busy", busy, 0);
                if (exp_done.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done: got done at cycle %0d expected none", cyc);
                end else chk("done_cycle", cyc, exp_done.pop_front());
            end else if (out) begin
                if (!in_bit) begin
                    in_bit = 1;
                    hc = 0;
                    lc = 0;
                end else if (lc > 0) begin
                    check_bit(0);
                    hc = 0;
                    lc = 0;
                end
                hc++;
            end else if (in_bit) lc++;
            if (int'(address) != prev_addr) begin
                if (exp_addr.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_address: got %0d expected no change", address);
                end else chk("address", address, exp_addr.pop_front());
            end
        end
        prev_addr = int'(address);
    end

    task automatic set_led(input int i, input logic [BITS-1:0] w, input logic [BITS-1:0] e);
        mem[i]  = w;
        expw[i] = e;
    endtask

    task automatic go(input int n);
        @(negedge clk);
        for (int i = 0; i < n; i++)
            for (int j = BITS - 1; j >= 0; j--) exp_bits.push_back(expw[i][j]);
        for (int i = 1; i < n; i++) exp_addr.push_back(i);
        if (n > 1) exp_addr.push_back(0);
        num_leds = (AW + 1)'(n);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        last_e0 = cyc;
        exp_done.push_back(cyc + (n == 0 ? 1 + RES : 2 + n * BITS * 8 + RES));
    endtask

    task automatic finish_frame(input string name);
        for (int k = 0; k < 5000 && exp_done.size() != 0; k++) @(negedge clk);
        if (exp_done.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: got no done expected done", name);
            exp_done.delete();
        end
        @(negedge clk);
        chk({name, "_bits_left"}, exp_bits.size(), 0);
        chk({name, "_addr_left"}, exp_addr.size(), 0);
        exp_bits.delete();
        exp_addr.delete();
        in_bit = 0;
    endtask

    initial begin
        for (int i = 0; i < 64; i++) set_led(i, '0, '0);
        repeat (3) @(negedge clk);
        chk("rst_out", out, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_address", address, 0);
        rst = 1'b0;

        set_led(0, 24'h800001, 24'h800001);
        go(1);
        finish_frame("t1");

        set_led(0, 24'hFFFFFF, 24'hFFFFFF);
        set_led(1, 24'h000000, 24'h000000);
        set_led(2, 24'hAAAAAA, 24'hAAAAAA);
        go(3);
        finish_frame("t2");

        go(0);
        finish_frame("t3");

        set_led(0, 24'h123456, 24'h123456);
        set_led(1, 24'hA5C3F0, 24'hA5C3F0);
        go(2);
        while (cyc < last_e0 + 254) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_out", out, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_address", address, 0);
        chk("midrst_done", done, 0);
        @(negedge clk);
        exp_bits.delete();
        exp_addr.delete();
        exp_done.delete();
        in_bit = 0;
        rst = 1'b0;
        go(2);
        finish_frame("t4");

        set_led(0, 24'h0F0F0F, 24'h0F0F0F);
        set_led(1, 24'hC00003, 24'hC00003);
        go(2);
        repeat (100) @(negedge clk);
        num_leds = 7'd5;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("t5_busy", busy, 1);
        finish_frame("t5");

`ifdef WS2812_BRIGHTNESS_EN
        brightness = 8'd127;
        set_led(0, 24'hFF8040, 24'h7F4020);
        go(1);
        finish_frame("t6a");
        brightness = 8'd255;
        set_led(0, 24'hFF8040, 24'hFF8040);
        go(1);
        finish_frame("t6b");
`endif

        repeat (20) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/ws2812_chain_driver.md
# ws2812_chain_driver

Parametrised serial driver for WS2812/SK6812-class addressable LED chains. It streams a run-time-selected number of pixel words from a synchronous pixel memory and encodes each bit as a timed high/low pulse on a single output. It ends each frame with a latch (reset) low period and then pulses `done`. The block sits between the Wishbone-mapped pixel RAM and the LED pin.

## Interface
Parameters:
- `BITS_PER_LED`, 24: bits per pixel word; must be 24 (GRB) or 32 (GRBW).
- `ADDR_W`, 6: pixel memory address width; the chain holds up to 2^ADDR_W LEDs.
- `TIMER_W`, 16: width of the phase timer.
- `T0H`, 18: high cycles for a 0 bit.
- `T0L`, 40: low cycles for a 0 bit.
- `T1H`, 35: high cycles for a 1 bit.
- `T1L`, 30: low cycles for a 1 bit.
- `RES`, 2500: latch low cycles after the last bit.

Ports:
- `clk`, in, 1: single clock. The block has one clock; reset is synchronous and active-high.
- `rst`, in, 1: synchronous, active-high reset.
- `start`, in, 1: frame request; sampled only in IDLE.
- `num_leds`, in, ADDR_W+1: LED count; sampled on an accepted `start`.
- `data`, in, BITS_PER_LED: pixel word from memory. It is valid two edges after `address` changes.
- `address`, out, ADDR_W: pixel memory read address.
- `out`, out, 1: serial LED line; always driven as 0 or 1, never Z.
- `busy`, out, 1: high from the accepted `start` until `done`.
- `done`, out, 1: one-cycle pulse at the end of the frame.
- `brightness`, in, 8: global brightness. This port exists only with `WS2812_BRIGHTNESS_EN`.

## Operation
- Reset values: `out`=0, `done`=0, `busy`=0, `address`=0, state IDLE, all counters 0.
- States: IDLE → FETCH → LOAD → HIGH ⇄ LOW → (LOAD | LATCH) → IDLE.
- IDLE:
  - `start`=1 latches `num_leds` and sets `busy`.
  - If `num_leds`==0: go to LATCH.
  - Otherwise: go to FETCH with `address`=0.
- FETCH: wait one cycle for memory latency.
- LOAD: capture the pixel word into the shift register, set bit index 0, go to HIGH.
- Prefetch:
  - On every LOAD that is not of the final LED, `address` increments.
  - The next word is captured into a holding register two edges later.
  - The LOAD after the final bit of the current LED uses the holding register. There is no FETCH and no gap between LEDs.
- Bit order: MSB first (`data[BITS_PER_LED-1]` first).
- HIGH:
  - `out`=1 for T0H or T1H cycles, chosen by the current bit.
  - Then go to LOW.
- LOW:
  - `out`=0 for T0L or T1L cycles.
  - Then the next bit goes to HIGH.
  - After the last bit of an LED: if LED index == `num_leds`-1, go to LATCH; otherwise go to LOAD.
- LATCH:
  - `out`=0 for RES cycles.
  - Then `done`=1 for one cycle, `busy`=0, `address`=0, go to IDLE.
- `start` while `busy` is ignored and has no effect on the current frame.
- Width rules:
  - `num_leds` > 2^ADDR_W saturates to 2^ADDR_W.
  - `address` never wraps within a frame.
  - The timer counts down from N-1 to 0, so a phase lasts exactly N cycles.
- `rst` asserted mid-frame: on the next edge all outputs return to their reset values, including `out`=0. No `done` pulse is generated.

## Timing
- The edge that accepts `start` is E0.
- `address`=0 from E0. The word is loaded at E2, and `out` rises at E2.
- Each bit period is exactly TxH+TxL cycles.
- LED-to-LED transitions add 0 cycles.
- Frame length in cycles from E0 to the `done` pulse = 2 + Σ(bit periods) + RES.
- With `num_leds`=0: `done` pulses at E0+1+RES.
- Required parameter constraints: all T*H and T*L ≥ 3, and RES ≥ 1.
- `done` and `busy`=0 occur on the same edge. A new `start` can be accepted on the following edge.

## Configuration
- `WS2812_BRIGHTNESS_EN` defined:
  - Adds the `brightness` port, sampled on an accepted `start`.
  - Each 8-bit channel of every word is replaced by (c × (brightness+1)) >> 8 before it is shifted out. This is computed in the prefetch/LOAD path with no added latency.
  - brightness=255 passes data unchanged; brightness=0 outputs all zeros.
- `WS2812_BRIGHTNESS_EN` undefined: the port is absent and words are sent verbatim.

## Test plan
All scenarios use T0H=3, T0L=5, T1H=5, T1L=3, RES=10, BITS_PER_LED=24.
1. `num_leds`=1, mem[0]=0x800001:
   - `out` shows first bit 5 high/3 low, then 22 bits of 3 high/5 low, then last bit 5 high/3 low.
   - Then 10 low cycles, then `done` pulses at E0+2+192+10.
2. `num_leds`=3, mem[0..2]=0xFFFFFF, 0x000000, 0xAAAAAA:
   - `address` sequence is 0, 1, 2.
   - `out` is continuous with no extra cycles between LEDs.
   - `done` appears exactly once.
3. `num_leds`=0: `out` stays 0 and `done` pulses at E0+11.
4. Reset mid-frame: assert `rst` during bit 7 of LED 1.
   - Next edge: `out`=0, `busy`=0, `address`=0, no `done`.
   - A new `start` then produces a full, correct frame.
5. `start` pulsed again mid-frame: frame length and data are unchanged and `done` appears once.
6. With `WS2812_BRIGHTNESS_EN`: brightness=127 and mem[0]=0xFF8040 transmit 0x7F4020; brightness=255 transmits 0xFF8040.
